// File: rtl/serial_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_loader_pkg;

  localparam int          CLKS_PER_BIT_DEF = 434;   // 50 MHz / 115200 baud
  localparam int          ADDR_W_DEF       = 4;
  localparam int          MEM_DEPTH_DEF    = 16;
  localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LOAD,
    WRITE,
    DONE
  } ld_state_e;

endpackage

// File: rtl/serial_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchroniser; mid-bit sampling.
// Latency: rx_valid/rx_err pulse in the cycle the stop bit is sampled (~9.5 bit times after start edge + 2 sync cycles).
// Backpressure: none; the consumer must take rx_byte on the rx_valid cycle.
module uart_rx
  import serial_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  // Two-flop synchroniser; preset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: half a bit to reach mid-start, then whole bits to each data/stop midpoint.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line that is high again at mid-start was a glitch, not a character.
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};   // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          rx_valid = rx_sync_q;
          rx_err   = !rx_sync_q;
          cnt_d    = '0;
          state_d  = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/serial_loader.sv
// UART-to-memory programmer: waits for a sync byte, then writes the next MEM_DEPTH bytes to addresses 0..MEM_DEPTH-1.
// Latency: serial_WE 1 cycle after a data byte's rx_valid; done 1 cycle after the final serial_WE.
// Backpressure: none; the memory port must accept every one-cycle strobe.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int         MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int         ADDR_W       = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              serial_WE,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [7:0]        serial_value,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(MEM_DEPTH - 1);

  logic       rx_valid;
  logic       rx_err;
  logic [7:0] rx_byte;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        value_q, value_d;
  logic              ferr_q, ferr_d;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_err   (rx_err)
  );

  // Loader state, byte counter and held write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      cnt_q   <= '0;
      addr_q  <= '0;
      value_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: a framing error anywhere is remembered; inside an image it also abandons the load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    value_d = value_q;
    ferr_d  = ferr_q || rx_err;
    case (state_q)
      WAIT_SYNC: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = LOAD;
          cnt_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      LOAD: begin
        if (rx_err) begin
          state_d = WAIT_SYNC;
          cnt_d   = '0;
        end else if (rx_valid) begin
          // Any value, including SYNC_BYTE, is payload once synced.
          state_d = WRITE;
          value_d = rx_byte;
          addr_d  = cnt_q;
        end
      end
      WRITE: begin
        if (rx_err) begin
          state_d = WAIT_SYNC;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = WAIT_SYNC;
        cnt_d   = '0;
      end
      default: begin
        state_d = WAIT_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes decode straight from the registered state, so each lasts exactly one cycle.
  assign serial_WE    = (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign busy         = (state_q == LOAD) || (state_q == WRITE);
  assign serial_addr  = addr_q;
  assign serial_value = value_q;
  assign frame_err    = ferr_q;

endmodule
